// File: rtl/rvr32_pkg.sv
// rtl/rvr32_pkg.sv - comparator op encodings and response source constants
// Shared by the comparator and its scheduler.
package rvr32_pkg;

  // Values match the RV32 branch funct3 field so decode can pass it straight through.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_e;

  localparam logic SRC_BR  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/rvr32_cmp.sv
// rtl/rvr32_cmp.sv - combinational 32-bit comparator for branch and set-less-than
// Undefined op encodings return 0.
module rvr32_cmp
  import rvr32_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  op_i,
  output logic        result_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    result_o = 1'b0;
    case (op_i)
      CMP_EQ:  result_o = eq;
      CMP_NE:  result_o = ~eq;
      CMP_LT:  result_o = lt_s;
      CMP_GE:  result_o = ~lt_s;
      CMP_LTU: result_o = lt_u;
      CMP_GEU: result_o = ~lt_u;
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rvr32_cmp_sched.sv
// rtl/rvr32_cmp_sched.sv - shares one comparator between branch unit and ALU slt path
// Branch has priority; ALU wins after STARVE_MAX consecutive branch wins over it.
module rvr32_cmp_sched
  import rvr32_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [31:0]      br_rs1,
  input  logic [31:0]      br_rs2,
  input  logic [2:0]       br_op,
  input  logic [TAG_W-1:0] br_tag,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [31:0]      alu_rs1,
  input  logic [31:0]      alu_rs2,
  input  logic [2:0]       alu_op,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_result
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic             vld_q, vld_d;
  logic             src_q, src_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             res_q, res_d;
  logic [SC_W-1:0]  sc_q, sc_d;

  logic        can_acc;
  logic        hit;
  logic        br_hs;
  logic        alu_hs;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_op;
  logic        cmp_res;

  assign can_acc = ~vld_q | rsp_ready;
  assign hit     = (sc_q == SC_W'(STARVE_MAX));

  // The two grant conditions are mutually exclusive whenever both requesters are valid.
  assign br_ready  = ~rst & can_acc & ~flush & ~(alu_valid & hit);
  assign alu_ready = ~rst & can_acc & (~br_valid | flush | hit);
  assign br_hs     = br_valid & br_ready;
  assign alu_hs    = alu_valid & alu_ready;

  assign cmp_a  = alu_hs ? alu_rs1 : br_rs1;
  assign cmp_b  = alu_hs ? alu_rs2 : br_rs2;
  assign cmp_op = alu_hs ? alu_op  : br_op;

  rvr32_cmp u_cmp (
    .rs1_i    (cmp_a),
    .rs2_i    (cmp_b),
    .op_i     (cmp_op),
    .result_o (cmp_res)
  );

  always_comb begin
    vld_d = vld_q;
    src_d = src_q;
    tag_d = tag_q;
    res_d = res_q;
    sc_d  = sc_q;
    if (br_hs | alu_hs) begin
      vld_d = 1'b1;
      src_d = alu_hs ? SRC_ALU : SRC_BR;
      tag_d = alu_hs ? alu_tag : br_tag;
      res_d = cmp_res;
    end else if (vld_q & (rsp_ready | (flush & (src_q == SRC_BR)))) begin
      // Consumed, or a branch result squashed by flush.
      vld_d = 1'b0;
    end
    if (alu_hs) begin
      sc_d = '0;
    end else if (br_hs & alu_valid & ~hit) begin
      sc_d = sc_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      src_q <= SRC_BR;
      tag_q <= '0;
      res_q <= 1'b0;
      sc_q  <= '0;
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
      tag_q <= tag_d;
      res_q <= res_d;
      sc_q  <= sc_d;
    end
  end

  assign rsp_valid  = vld_q & ~(flush & (src_q == SRC_BR));
  assign rsp_src    = src_q;
  assign rsp_tag    = tag_q;
  assign rsp_result = res_q;

endmodule

// File: tb/tb_rvr32_cmp_sched.sv
// tb/tb_rvr32_cmp_sched.sv - self-checking bench for rvr32_cmp_sched
module tb_rvr32_cmp_sched;
  import rvr32_pkg::*;

  localparam int TAG_W      = 4;
  localparam int STARVE_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             br_valid, br_ready;
  logic [31:0]      br_rs1, br_rs2;
  logic [2:0]       br_op;
  logic [TAG_W-1:0] br_tag;
  logic             alu_valid, alu_ready;
  logic [31:0]      alu_rs1, alu_rs2;
  logic [2:0]       alu_op;
  logic [TAG_W-1:0] alu_tag;
  logic             flush;
  logic             rsp_valid, rsp_ready, rsp_src, rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rvr32_cmp_sched #(.TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_rs1     (br_rs1),
    .br_rs2     (br_rs2),
    .br_op      (br_op),
    .br_tag     (br_tag),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_op     (alu_op),
    .alu_tag    (alu_tag),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag),
    .rsp_result (rsp_result)
  );

  // The scheduler passes ALU ops through unchecked; only legal ones may be offered.
  always @(negedge clk) begin
    if (!rst && alu_valid) begin
      assert (alu_op == CMP_LT || alu_op == CMP_LTU)
        else $error("illegal alu_op %0h offered", alu_op);
    end
  end

  function automatic logic ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      CMP_EQ:  return ua == ub;
      CMP_NE:  return ua != ub;
      CMP_LT:  return sa < sb;
      CMP_GE:  return sa >= sb;
      CMP_LTU: return ua < ub;
      CMP_GEU: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return 32'h8000_0000 + 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid  = 1'b0;
    br_rs1    = '0;
    br_rs2    = '0;
    br_op     = CMP_EQ;
    br_tag    = '0;
    alu_valid = 1'b0;
    alu_rs1   = '0;
    alu_rs2   = '0;
    alu_op    = CMP_LT;
    alu_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    br_valid = 1'b1; br_rs1 = 32'd1; br_rs2 = 32'd2; br_op = CMP_LT; br_tag = TAG_W'(10);
    alu_valid = 1'b1; alu_rs1 = 32'd5; alu_rs2 = 32'd3; alu_op = CMP_LTU; alu_tag = TAG_W'(5);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if ({br_ready, alu_ready} !== 2'b00) begin
        n_fail++; $display("FAIL reset_readies: got %b required 00", {br_ready, alu_ready});
      end
      n_cmp++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== '0) begin
        n_fail++; $display("FAIL reset_rsp: got v%b s%b t%h r%b required all 0", rsp_valid, rsp_src, rsp_tag, rsp_result);
      end
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({br_ready, alu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL release_readies: got %b required 10", {br_ready, alu_ready});
    end
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_BR, TAG_W'(10), 1'b1}) begin
      n_fail++; $display("FAIL first_rsp: got v%b s%b t%h r%b required v1 s0 ta r1", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_ALU, TAG_W'(5), 1'b0}) begin
      n_fail++; $display("FAIL second_rsp: got v%b s%b t%h r%b required v1 s1 t5 r0", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    next_cycle();
  endtask

  task automatic test_branch_ops();
    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic [2:0]  vop[4];
    logic        vexp[4];
    va   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0};
    vb   = '{32'h1, 32'h1, 32'h5, 32'h1};
    vop  = '{CMP_LT, CMP_LTU, CMP_EQ, CMP_GEU};
    vexp = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      br_valid = 1'b1; br_rs1 = va[i]; br_rs2 = vb[i]; br_op = vop[i]; br_tag = TAG_W'(i + 1);
      @(negedge clk);
      n_cmp++;
      if (br_ready !== 1'b1) begin
        n_fail++; $display("FAIL op%0d_ready: got %b required 1", i, br_ready);
      end
      next_cycle();
      br_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_BR, TAG_W'(i + 1), vexp[i]}) begin
        n_fail++; $display("FAIL op%0d_result: got v%b s%b t%h r%b required v1 s0 t%h r%b",
                           i, rsp_valid, rsp_src, rsp_tag, rsp_result, TAG_W'(i + 1), vexp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    int exp_g[8];
    int g;
    exp_g = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    br_valid = 1'b1; br_rs1 = 32'd1; br_rs2 = 32'd1; br_op = CMP_EQ; br_tag = '0;
    alu_valid = 1'b1; alu_rs1 = 32'd1; alu_rs2 = 32'd2; alu_op = CMP_LT; alu_tag = TAG_W'(8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = (alu_valid && alu_ready) ? 1 : (br_valid && br_ready) ? 0 : 2;
      n_cmp++;
      if (g !== exp_g[i]) begin
        n_fail++; $display("FAIL starve_grant%0d: got %0d required %0d", i, g, exp_g[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if ({rsp_valid, rsp_src} !== {1'b1, exp_g[i-1] == 1}) begin
          n_fail++; $display("FAIL starve_rsp%0d: got v%b s%b required v1 s%0d", i, rsp_valid, rsp_src, exp_g[i-1]);
        end
      end
      next_cycle();
      if (g == 1) alu_tag = alu_tag + 1'b1;
      else        br_tag  = br_tag + 1'b1;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    br_valid = 1'b1; br_rs1 = 32'd3; br_rs2 = 32'd3; br_op = CMP_EQ; br_tag = TAG_W'(7);
    next_cycle();
    br_op = CMP_NE; br_tag = TAG_W'(8);
    alu_valid = 1'b1; alu_rs1 = 32'd1; alu_rs2 = 32'd2; alu_op = CMP_LT; alu_tag = TAG_W'(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_BR, TAG_W'(7), 1'b1}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v%b s%b t%h r%b required v1 s0 t7 r1", i, rsp_valid, rsp_src, rsp_tag, rsp_result);
      end
      n_cmp++;
      if ({br_ready, alu_ready} !== 2'b00) begin
        n_fail++; $display("FAIL bp_readies%0d: got %b required 00", i, {br_ready, alu_ready});
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({br_ready, alu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_resume: got %b required 10", {br_ready, alu_ready});
    end
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_BR, TAG_W'(8), 1'b0}) begin
      n_fail++; $display("FAIL bp_br_after: got v%b s%b t%h r%b required v1 s0 t8 r0", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_ALU, TAG_W'(3), 1'b1}) begin
      n_fail++; $display("FAIL bp_alu_after: got v%b s%b t%h r%b required v1 s1 t3 r1", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    next_cycle();
  endtask

  task automatic test_flush_held();
    do_reset();
    rsp_ready = 1'b0;
    br_valid = 1'b1; br_rs1 = 32'd1; br_rs2 = 32'd2; br_op = CMP_LT; br_tag = TAG_W'(2);
    next_cycle();
    br_valid = 1'b0;
    alu_valid = 1'b1; alu_rs1 = 32'd2; alu_rs2 = 32'd1; alu_op = CMP_LTU; alu_tag = TAG_W'(9);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, alu_ready} !== 3'b100) begin
      n_fail++; $display("FAIL flush_pre: got v%b s%b ar%b required 1 0 0", rsp_valid, rsp_src, alu_ready);
    end
    next_cycle();
    flush = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, alu_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_drop: got v%b ar%b required v0 ar1", rsp_valid, alu_ready);
    end
    next_cycle();
    flush = 1'b0;
    alu_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, SRC_ALU, TAG_W'(9), 1'b0}) begin
      n_fail++; $display("FAIL flush_alu_rsp: got v%b s%b t%h r%b required v1 s1 t9 r0", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    next_cycle();
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    flush = 1'b1;
    br_valid = 1'b1; br_rs1 = 32'd4; br_rs2 = 32'd4; br_op = CMP_EQ; br_tag = TAG_W'(4);
    @(negedge clk);
    n_cmp++;
    if (br_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_br_ready: got %b required 0", br_ready);
    end
    next_cycle();
    flush = 1'b0;
    br_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_rsp: got %b required 0", rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    br_valid = 1'b1; br_rs1 = 32'd0; br_rs2 = 32'd9; br_op = CMP_LTU; br_tag = TAG_W'(6);
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_tag} !== {1'b1, TAG_W'(6)}) begin
      n_fail++; $display("FAIL rmid_pre: got v%b t%h required v1 t6", rsp_valid, rsp_tag);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== '0) begin
      n_fail++; $display("FAIL rmid_post: got v%b s%b t%h r%b required all 0", rsp_valid, rsp_src, rsp_tag, rsp_result);
    end
    rsp_ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_random();
    logic [2:0] br_ops[6];
    logic m_vld, m_src, m_res;
    logic [TAG_W-1:0] m_tag;
    int   streak;
    logic br_pend, alu_pend, room, exp_br, exp_alu;
    br_ops = '{CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};
    do_reset();
    m_vld = 1'b0; m_src = 1'b0; m_res = 1'b0; m_tag = '0; streak = 0;
    br_pend = 1'b0; alu_pend = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!br_pend && $urandom_range(0, 2) != 0) begin
        br_pend = 1'b1;
        br_rs1 = rand_opnd(); br_rs2 = rand_opnd();
        br_op = br_ops[$urandom_range(0, 5)]; br_tag = TAG_W'($urandom);
      end
      if (!alu_pend && $urandom_range(0, 2) != 0) begin
        alu_pend = 1'b1;
        alu_rs1 = rand_opnd(); alu_rs2 = rand_opnd();
        alu_op = $urandom_range(0, 1) ? CMP_LT : CMP_LTU; alu_tag = TAG_W'($urandom);
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush && br_pend && $urandom_range(0, 1) == 1) br_pend = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      br_valid  = br_pend;
      alu_valid = alu_pend;
      @(negedge clk);
      // Branch first, unless flushed or the ALU has already lost STARVE_MAX times in a row.
      room    = !m_vld || rsp_ready;
      exp_alu = room && alu_pend && (flush || !br_pend || streak >= STARVE_MAX);
      exp_br  = room && br_pend && !flush && !exp_alu;
      n_cmp++;
      if (rsp_valid !== (m_vld && !(flush && m_src == SRC_BR))) begin
        n_fail++; $display("FAIL rnd%0d_rsp_valid: got %b required %b", cyc, rsp_valid, m_vld && !(flush && m_src == SRC_BR));
      end
      if (m_vld) begin
        n_cmp++;
        if ({rsp_src, rsp_tag, rsp_result} !== {m_src, m_tag, m_res}) begin
          n_fail++; $display("FAIL rnd%0d_rsp: got s%b t%h r%b required s%b t%h r%b",
                             cyc, rsp_src, rsp_tag, rsp_result, m_src, m_tag, m_res);
        end
      end
      n_cmp++;
      if ({br_valid && br_ready, alu_valid && alu_ready} !== {exp_br, exp_alu}) begin
        n_fail++; $display("FAIL rnd%0d_grant: got br%b alu%b required br%b alu%b",
                           cyc, br_valid && br_ready, alu_valid && alu_ready, exp_br, exp_alu);
      end
      if (exp_alu) begin
        m_vld = 1'b1; m_src = SRC_ALU; m_tag = alu_tag; m_res = ref_cmp(alu_op, alu_rs1, alu_rs2);
        streak = 0;
        alu_pend = 1'b0;
      end else if (exp_br) begin
        m_vld = 1'b1; m_src = SRC_BR; m_tag = br_tag; m_res = ref_cmp(br_op, br_rs1, br_rs2);
        if (alu_pend && streak < STARVE_MAX) streak++;
        br_pend = 1'b0;
      end else if (m_vld && (rsp_ready || (flush && m_src == SRC_BR))) begin
        m_vld = 1'b0;
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_branch_ops();
    test_starvation();
    test_backpressure();
    test_flush_held();
    test_flush_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
